// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller driven by one-cycle keypad events.
// Define TTT_TIMEOUT_EN to add a turn timer that forfeits idle turns.
module ttt_game_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [17:0] board,
    output logic        is_main,
    output logic        turn_o,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_cnt,
    output logic        move_err,
    output logic        timeout
);

    typedef enum logic [2:0] {
        MAIN,
        WAIT,
        CHECK,
        PLACE,
        EVAL,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_board;
    logic [17:0] w_board_nxt;
    logic [3:0]  r_cell;
    logic [3:0]  w_cell_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_turn;
    logic        w_turn_nxt;
    logic [1:0]  r_winner;
    logic [1:0]  w_winner_nxt;
    logic        r_move_err;
    logic        w_move_err_nxt;
    logic        w_expire;

    logic w_key_cell;
    logic w_key_start;
    logic w_key_abort;
    logic w_key_bad;

    assign w_key_cell  = key_valid && key_code >= 4'd1
                         && key_code <= 4'd9;
    assign w_key_start = key_valid && key_code == 4'd10;
    assign w_key_abort = key_valid && key_code == 4'd11;
    assign w_key_bad   = key_valid && (key_code == 4'd0
                         || key_code >= 4'd12);

    logic [1:0] w_mark;
    assign w_mark = r_turn ? 2'b10 : 2'b01;

    function automatic logic line3(
        input logic [17:0] b,
        input int          a,
        input int          c,
        input int          d,
        input logic [1:0]  m
    );
        return b[2*a +: 2] == m && b[2*c +: 2] == m
               && b[2*d +: 2] == m;
    endfunction

    // The board is already updated when EVAL runs, so test the mover's mark.
    logic w_win;
    assign w_win = line3(r_board, 0, 1, 2, w_mark)
                || line3(r_board, 3, 4, 5, w_mark)
                || line3(r_board, 6, 7, 8, w_mark)
                || line3(r_board, 0, 3, 6, w_mark)
                || line3(r_board, 1, 4, 7, w_mark)
                || line3(r_board, 2, 5, 8, w_mark)
                || line3(r_board, 0, 4, 8, w_mark)
                || line3(r_board, 2, 4, 6, w_mark);

    // Read back the contents of the latched cell for the occupancy check.
    logic [1:0] w_cell_val;
    always_comb begin
        w_cell_val = 2'b00;
        for (int i = 0; i < 9; i++)
            if (r_cell == 4'(i))
                w_cell_val = r_board[2*i +: 2];
    end

    // Next-state and datapath update; abort pre-empts every other transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_board_nxt    = r_board;
        w_cell_nxt     = r_cell;
        w_cnt_nxt      = r_cnt;
        w_turn_nxt     = r_turn;
        w_winner_nxt   = r_winner;
        w_move_err_nxt = 1'b0;
        if (w_key_abort && r_state != MAIN) begin
            w_state_nxt  = MAIN;
            w_board_nxt  = '0;
            w_cnt_nxt    = '0;
            w_turn_nxt   = 1'b0;
            w_winner_nxt = 2'b00;
        end else begin
            unique case (r_state)
                MAIN: begin
                    if (w_key_start) begin
                        w_state_nxt  = WAIT;
                        w_board_nxt  = '0;
                        w_cnt_nxt    = '0;
                        w_turn_nxt   = 1'b0;
                        w_winner_nxt = 2'b00;
                    end
                end
                WAIT: begin
                    if (w_key_cell) begin
                        w_state_nxt = CHECK;
                        w_cell_nxt  = key_code - 4'd1;
                    end else if (w_key_bad) begin
                        w_move_err_nxt = 1'b1;
                    end else if (w_expire) begin
                        w_turn_nxt = ~r_turn;
                    end
                end
                CHECK: begin
                    if (w_cell_val != 2'b00) begin
                        w_move_err_nxt = 1'b1;
                        w_state_nxt    = WAIT;
                    end else begin
                        w_state_nxt = PLACE;
                    end
                end
                PLACE: begin
                    for (int i = 0; i < 9; i++)
                        if (r_cell == 4'(i))
                            w_board_nxt[2*i +: 2] = w_mark;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_state_nxt = EVAL;
                end
                EVAL: begin
                    if (w_win) begin
                        w_state_nxt  = DONE;
                        w_winner_nxt = w_mark;
                    end else if (r_cnt == 4'd9) begin
                        w_state_nxt  = DONE;
                        w_winner_nxt = 2'b00;
                    end else begin
                        w_turn_nxt  = ~r_turn;
                        w_state_nxt = WAIT;
                    end
                end
                DONE: begin
                    if (w_key_start)
                        w_state_nxt = MAIN;
                end
                default: w_state_nxt = MAIN;
            endcase
        end
    end

    // State and datapath registers; reset discards any move in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= MAIN;
            r_board    <= '0;
            r_cell     <= '0;
            r_cnt      <= '0;
            r_turn     <= 1'b0;
            r_winner   <= 2'b00;
            r_move_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_board    <= w_board_nxt;
            r_cell     <= w_cell_nxt;
            r_cnt      <= w_cnt_nxt;
            r_turn     <= w_turn_nxt;
            r_winner   <= w_winner_nxt;
            r_move_err <= w_move_err_nxt;
        end
    end

`ifdef TTT_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_timeout;
    logic        w_tmo_hit;

    assign w_tmo_hit = r_tmo_cnt == TIMEOUT_CYCLES - 32'd1;
    assign w_expire  = r_state == WAIT && w_tmo_hit && !key_valid;

    // Turn timer: counts WAIT cycles, wraps at expiry, held clear elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state != WAIT || w_tmo_hit)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_expire     = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign board     = r_board;
    assign is_main   = r_state == MAIN;
    assign turn_o    = r_turn;
    assign game_over = r_state == DONE;
    assign winner    = r_winner;
    assign move_cnt  = r_cnt;
    assign move_err  = r_move_err;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: table vectors, hand-written corner sequences and
// randomized keys checked against a game-level reference model.
module tb_ttt_game_ctrl;

    localparam int TB_TMO = 8;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        is_main;
    logic        turn_o;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  move_cnt;
    logic        move_err;
    logic        timeout;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(32'd8)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .board     (board),
        .is_main   (is_main),
        .turn_o    (turn_o),
        .game_over (game_over),
        .winner    (winner),
        .move_cnt  (move_cnt),
        .move_err  (move_err),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    // Reference model: the game as seen by a player, plus release times
    // for the delayed outputs of an accepted move.
    int m_board [9];
    int p_board [9];
    int m_cnt, m_turn, m_win, p_cnt, p_turn, p_win;
    bit m_main, m_over, m_err, m_tmo, p_over;
    int due_b, due_t, due_e, busy_end, idle;

    function automatic bit wins(input int b [9], input int m);
        for (int l = 0; l < 8; l++)
            if (b[LINES[l][0]] == m && b[LINES[l][1]] == m
                && b[LINES[l][2]] == m)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] pack(input int b [9]);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++)
            r[2*i +: 2] = 2'(b[i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_cnt = 0; m_turn = 0; m_win = 0; m_over = 0;
        due_b = -1; due_t = -1; due_e = -1; busy_end = -1; idle = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_main = 1; m_err = 0; m_tmo = 0;
    endtask

    task automatic model_edge(input bit v, input logic [3:0] k);
        bit in_wait;
        int idx, mark;
        cyc++;
        m_err = 0;
        m_tmo = 0;
        in_wait = !m_main && !m_over && cyc > busy_end;
        if (v && k == 4'd11 && !m_main) begin
            model_clear();
            m_main = 1;
            return;
        end
        if (due_e == cyc) m_err = 1;
        if (due_b == cyc) begin
            m_board = p_board;
            m_cnt = p_cnt;
        end
        if (due_t == cyc) begin
            m_turn = p_turn; m_over = p_over; m_win = p_win;
        end
`ifdef TTT_TIMEOUT_EN
        if (in_wait) begin
            if (idle == TB_TMO - 1) begin
                idle = 0;
                if (!v) begin m_tmo = 1; m_turn = 1 - m_turn; end
            end else begin
                idle++;
            end
        end else begin
            idle = 0;
        end
`endif
        if (!v || cyc <= busy_end) return;
        if (m_main) begin
            if (k == 4'd10) begin model_clear(); m_main = 0; end
        end else if (m_over) begin
            if (k == 4'd10) begin m_main = 1; m_over = 0; end
        end else if (k >= 4'd1 && k <= 4'd9) begin
            idx = int'(k) - 1;
            if (m_board[idx] != 0) begin
                due_e = cyc + 1;
                busy_end = cyc + 1;
            end else begin
                mark = m_turn ? 2 : 1;
                p_board = m_board;
                p_board[idx] = mark;
                p_cnt = m_cnt + 1;
                p_win = m_win;
                p_turn = m_turn;
                p_over = 1;
                if (wins(p_board, mark)) p_win = mark;
                else if (p_cnt == 9) p_win = 0;
                else begin p_over = 0; p_turn = 1 - m_turn; end
                due_b = cyc + 2;
                due_t = cyc + 3;
                busy_end = cyc + 3;
            end
        end else if (k == 4'd0 || k >= 4'd12) begin
            m_err = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                     nm, cyc, got, exp);
        end
    endtask

    task automatic compare_model();
        chk("board", 32'(board), 32'(pack(m_board)));
        chk("move_cnt", 32'(move_cnt), 32'(m_cnt));
        chk("turn_o", 32'(turn_o), 32'(m_turn));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("is_main", 32'(is_main), 32'(m_main));
        chk("move_err", 32'(move_err), 32'(m_err));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        if (m_over) chk("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic step(input bit v, input logic [3:0] k);
        key_valid = v;
        key_code  = k;
        @(posedge clk);
        model_edge(v, k);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        compare_model();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".board"}, 32'(board), 0);
        chk({tag, ".is_main"}, 32'(is_main), 1);
        chk({tag, ".turn_o"}, 32'(turn_o), 0);
        chk({tag, ".game_over"}, 32'(game_over), 0);
        chk({tag, ".winner"}, 32'(winner), 0);
        chk({tag, ".move_cnt"}, 32'(move_cnt), 0);
        chk({tag, ".move_err"}, 32'(move_err), 0);
        chk({tag, ".timeout"}, 32'(timeout), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        model_reset();
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [17:0] brd;
        logic [3:0]  cnt;
        logic        turn;
        logic        over;
        logic [1:0]  win;
        logic        main;
    } vec_t;

    vec_t tbl [$];
    int   errs;

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        model_reset();

        // X wins on the top row, DONE ignores cells, restart, then a draw.
        tbl.push_back('{4'd10, 18'h00000, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd1,  18'h00001, 4'd1, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd4,  18'h00081, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd2,  18'h00085, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd5,  18'h00285, 4'd4, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd3,  18'h00295, 4'd5, 1'b0, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'd7,  18'h00295, 4'd5, 1'b0, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'd10, 18'h00295, 4'd5, 1'b0, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'd10, 18'h00000, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd1,  18'h00001, 4'd1, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd2,  18'h00009, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd3,  18'h00019, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd5,  18'h00219, 4'd4, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd4,  18'h00259, 4'd5, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd6,  18'h00A59, 4'd6, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd8,  18'h04A59, 4'd7, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd7,  18'h06A59, 4'd8, 1'b0, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'd9,  18'h16A59, 4'd9, 1'b0, 1'b1, 2'd0, 1'b0});

        do_reset();
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].key);
            idle_n(4);
            chk($sformatf("tbl%0d.board", i), 32'(board), 32'(tbl[i].brd));
            chk($sformatf("tbl%0d.cnt", i), 32'(move_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.turn", i), 32'(turn_o), 32'(tbl[i].turn));
            chk($sformatf("tbl%0d.over", i), 32'(game_over), 32'(tbl[i].over));
            chk($sformatf("tbl%0d.main", i), 32'(is_main), 32'(tbl[i].main));
            if (tbl[i].over)
                chk($sformatf("tbl%0d.win", i), 32'(winner), 32'(tbl[i].win));
        end

        // Second press on an occupied cell: exactly one error pulse.
        do_reset();
        step(1'b1, 4'd10);
        step(1'b1, 4'd5);
        idle_n(4);
        errs = 0;
        step(1'b1, 4'd5);
        errs += int'(move_err);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0);
            errs += int'(move_err);
        end
        chk("dup.err_pulses", 32'(errs), 1);
        chk("dup.board", 32'(board), 32'h100);
        chk("dup.turn", 32'(turn_o), 1);

        // Invalid key in WAIT pulses move_err in the following cycle.
        step(1'b1, 4'd13);
        chk("bad.err", 32'(move_err), 1);
        step(1'b1, 4'd10);
        chk("start_in_wait.main", 32'(is_main), 0);

        // Abort while the second move is in CHECK.
        do_reset();
        step(1'b1, 4'd10);
        step(1'b1, 4'd1);
        idle_n(4);
        step(1'b1, 4'd2);
        step(1'b1, 4'd11);
        chk("abort.main", 32'(is_main), 1);
        chk("abort.board", 32'(board), 0);
        idle_n(3);
        chk("abort.board_later", 32'(board), 0);
        chk("abort.cnt", 32'(move_cnt), 0);

        // Keys arriving in CHECK, PLACE and EVAL are dropped.
        do_reset();
        step(1'b1, 4'd10);
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd4);
        idle_n(2);
        chk("drop.cnt", 32'(move_cnt), 1);
        chk("drop.board", 32'(board), 1);

        // Reset during PLACE discards the move; first key after is honoured.
        do_reset();
        step(1'b1, 4'd10);
        step(1'b1, 4'd1);
        step(1'b0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_place");
        model_reset();
        #2;
        rst = 1'b0;
        step(1'b1, 4'd10);
        chk("post_rst.main", 32'(is_main), 0);
        idle_n(3);
        chk("post_rst.board", 32'(board), 0);

`ifdef TTT_TIMEOUT_EN
        do_reset();
        step(1'b1, 4'd10);
        errs = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'd0);
            errs += int'(timeout);
        end
        step(1'b0, 4'd0);
        chk("tmo.early", 32'(errs), 0);
        chk("tmo.pulse", 32'(timeout), 1);
        chk("tmo.turn", 32'(turn_o), 1);
        chk("tmo.board", 32'(board), 0);
        errs = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'd0);
            errs += int'(timeout);
        end
        step(1'b1, 4'd5);
        errs += int'(timeout);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0);
            errs += int'(timeout);
        end
        chk("tmo.key_wins", 32'(errs), 0);
        chk("tmo.placed", 32'(board), 32'h200);
`endif

        // Randomized keys with occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int c;
            bit v;
            logic [3:0] k;
            v = $urandom_range(0, 99) < 40;
            c = $urandom_range(0, 99);
            if (c < 70) k = 4'($urandom_range(1, 9));
            else if (c < 85) k = 4'd10;
            else if (c < 88) k = 4'd11;
            else if (c < 94) k = 4'd0;
            else k = 4'($urandom_range(12, 15));
            step(v, k);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                compare_model();
                #1;
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
